keypad_scan: RTL



---
 rtl/keypad_pkg.sv | 39 +++
 rtl/keypad_colscan.sv | 78 +++++++
 rtl/keypad_scan.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 4x4 keypad scanner.
// Used by keypad_colscan and keypad_scan.
package keypad_pkg;

  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    HELD,
    RELEASE
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } res_t;

  function automatic logic [1:0] lows(input logic [3:0] r);
    logic [2:0] n;
    n = {2'b0, ~r[0]} + {2'b0, ~r[1]}
      + {2'b0, ~r[2]} + {2'b0, ~r[3]};
    return (n > 3'd2) ? 2'd2 : n[1:0];
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] r);
    logic [1:0] i;
    priority case (1'b1)
      !r[0]:   i = 2'd0;
      !r[1]:   i = 2'd1;
      !r[2]:   i = 2'd2;
      !r[3]:   i = 2'd3;
      default: i = 2'd0;
    endcase
    return i;
  endfunction

endpackage

// File: rtl/keypad_colscan.sv
// keypad_colscan: row synchronizer, column divider/drive and
// per-sweep accumulation into NONE / SINGLE(code) / MULTI.
module keypad_colscan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic             sweep_done,
  output res_t             kind,
  output logic [KEY_W-1:0] code
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [DW-1:0]    div;
  logic [1:0]       cidx;
  logic [3:0]       s1, s2;
  logic [1:0]       nacc;
  logic [KEY_W-1:0] cacc;
  logic             tick;
  logic [1:0]       ncol;
  logic [2:0]       sum;
  logic [1:0]       ntot;
  logic [KEY_W-1:0] code_c;

  assign tick = (div == DW'(SCAN_DIV - 1));
  assign ncol = lows(s2);
  assign sum  = {1'b0, nacc} + {1'b0, ncol};
  assign ntot = (sum > 3'd2) ? 2'd2 : sum[1:0];

  // the code is only meaningful while exactly one low has been seen
  assign code_c = (nacc == 2'd0 && ncol == 2'd1)
                ? {low_idx(s2), cidx} : cacc;

  assign col        = ~(4'b0001 << cidx);
  assign sweep_done = tick && (cidx == 2'd3);
  assign code       = code_c;

  always_comb begin
    kind = NONE;
    if (ntot == 2'd1)
      kind = SINGLE;
    else if (ntot == 2'd2)
      kind = MULTI;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 4'hF;
      s2   <= 4'hF;
      div  <= '0;
      cidx <= 2'd0;
      nacc <= 2'd0;
      cacc <= '0;
    end else begin
      s1 <= row;
      s2 <= s1;
      if (tick) begin
        div  <= '0;
        cidx <= cidx + 2'd1;
        if (cidx == 2'd3) begin
          nacc <= 2'd0;
          cacc <= '0;
        end else begin
          nacc <= ntot;
          cacc <= code_c;
        end
      end else begin
        div <= div + DW'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: debounced 4x4 keypad front end with valid/held outputs.
// Define KEYPAD_REPEAT_EN for auto-repeat strobes every REPEAT sweeps.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4,
  parameter int REPEAT   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  output logic [KEY_W-1:0] key,
  output logic             valid,
  output logic             held
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  if (SCAN_DIV < 4 || DEBOUNCE < 1 || REPEAT < 1) begin : g_bad
    $error("keypad_scan: parameter out of range");
  end

  logic             sweep_done;
  res_t             kind;
  logic [KEY_W-1:0] code;

  keypad_colscan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .clk        (clk),
    .rst        (rst),
    .row        (row),
    .col        (col),
    .sweep_done (sweep_done),
    .kind       (kind),
    .code       (code)
  );

  state_t           state, state_n;
  logic [KEY_W-1:0] cand, cand_n, key_n;
  logic [CW-1:0]    cnt, cnt_n, cnt_inc;
  logic             valid_n;
  logic             single;

  assign single  = (kind == SINGLE);
  assign cnt_inc = (cnt == CW'(DEBOUNCE)) ? cnt : cnt + CW'(1);

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT + 1);
  logic [RW-1:0] rcnt, rcnt_n, rinc;
  assign rinc = rcnt + RW'(1);
`endif

  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = cnt;
    key_n   = key;
    valid_n = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rcnt_n  = rcnt;
`endif
    if (sweep_done) begin
      unique case (state)
        IDLE: begin
          if (single) begin
            cand_n = code;
            cnt_n  = CW'(1);
            if (DEBOUNCE == 1) begin
              state_n = HELD;
              key_n   = code;
              valid_n = 1'b1;
            end else begin
              state_n = PRESS;
            end
          end
        end
        PRESS: begin
          if (single && code == cand) begin
            cnt_n = cnt_inc;
            if (cnt_inc >= CW'(DEBOUNCE)) begin
              state_n = HELD;
              key_n   = cand;
              valid_n = 1'b1;
            end
          end else if (single) begin
            cand_n = code;
            cnt_n  = CW'(1);
          end else begin
            state_n = IDLE;
          end
        end
        HELD: begin
          if (!(single && code == key)) begin
            cnt_n   = CW'(1);
            state_n = (DEBOUNCE == 1) ? IDLE : RELEASE;
          end
`ifdef KEYPAD_REPEAT_EN
          else if (rinc >= RW'(REPEAT)) begin
            valid_n = 1'b1;
            rcnt_n  = '0;
          end else begin
            rcnt_n = rinc;
          end
`endif
        end
        RELEASE: begin
          if (single && code == key) begin
            state_n = HELD;
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc >= CW'(DEBOUNCE))
              state_n = IDLE;
          end
        end
      endcase
    end
`ifdef KEYPAD_REPEAT_EN
    if ((state_n == HELD && state != HELD) || state == RELEASE)
      rcnt_n = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
      key   <= '0;
      valid <= 1'b0;
      held  <= 1'b0;
    end else begin
      state <= state_n;
      cand  <= cand_n;
      cnt   <= cnt_n;
      key   <= key_n;
      valid <= valid_n;
      held  <= (state_n == HELD) || (state_n == RELEASE);
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst)
      rcnt <= '0;
    else
      rcnt <= rcnt_n;
  end
`endif

endmodule
